// File: rtl/bp_initiator.sv
// rtl/bp_initiator.sv - BytePipe initiator: request to command byte stream, responses to local consumer
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cg                clock-gate enable; 0 holds all state and blocks every handshake
//   i_req_*, o_req_ready  transaction request (wr, 7b addr, len = extra beats)
//   i_wrdata*, o_wrdata_ready  write data stream, passed straight onto the link in WDATA
//   o_rsp_*, i_rsp_ready  response bytes to the local consumer, o_rsp_last marks the final byte
//   o_bp_*, i_bp_ready    BytePipe bytes towards the responder
//   i_bp_*, o_bp_ready    BytePipe bytes from the responder
//   o_busy              FSM not IDLE
//   o_timeout           sticky response-timeout flag, cleared by reset or the next accepted request
module bp_initiator #(
    parameter int TIMEOUT_W         = 16,
    parameter bit DISCARD_SETUP_RSP = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cg,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_wr,
    input  logic [6:0] i_req_addr,
    input  logic [7:0] i_req_len,
    input  logic [7:0] i_wrdata,
    input  logic       i_wrdata_valid,
    output logic       o_wrdata_ready,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_valid,
    output logic       o_rsp_last,
    input  logic       i_rsp_ready,
    output logic [7:0] o_bp_data,
    output logic       o_bp_valid,
    input  logic       i_bp_ready,
    input  logic [7:0] i_bp_data,
    input  logic       i_bp_valid,
    output logic       o_bp_ready,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP_CMD,
        SETUP_DAT,
        SETUP_RSP,
        CMD,
        WDATA,
        RSP
    } stateT;

    // The timeout fires on the idle cycle that would take the counter to
    // all-ones, i.e. after exactly 2^TIMEOUT_W-1 idle cycles.
    localparam logic [TIMEOUT_W-1:0] TO_FIRE = ~(TIMEOUT_W'(1));

    stateT                state;
    logic                 reqWr;
    logic [6:0]           reqAddr;
    logic [7:0]           reqLen;
    logic [7:0]           beatCnt;
    logic [TIMEOUT_W-1:0] toCnt;
    logic                 timeoutReg;

    logic [7:0] bpData;
    logic       bpValid;
    logic       bpReady;
    logic [7:0] rspData;
    logic       rspValid;
    logic       rspLast;
    logic       wrdataReady;

    logic       rspState;
    logic       bpFire;
    logic       rspFire;
    logic       toExpire;

    // Output decode: fixed bytes in command states, zero-latency
    // pass-through in WDATA and the response states.
    always_comb begin
        bpData      = 8'h00;
        bpValid     = 1'b0;
        bpReady     = 1'b0;
        rspData     = 8'h00;
        rspValid    = 1'b0;
        rspLast     = 1'b0;
        wrdataReady = 1'b0;
        case (state)
            SETUP_CMD: begin
                bpData  = 8'h80;
                bpValid = 1'b1;
            end
            SETUP_DAT: begin
                bpData  = reqLen;
                bpValid = 1'b1;
            end
            SETUP_RSP: begin
                if (DISCARD_SETUP_RSP) begin
                    bpReady = 1'b1;
                end else begin
                    bpReady  = i_rsp_ready;
                    rspData  = i_bp_data;
                    rspValid = i_bp_valid;
                end
            end
            CMD: begin
                bpData  = {reqWr, reqAddr};
                bpValid = 1'b1;
            end
            WDATA: begin
                bpData      = i_wrdata;
                bpValid     = i_wrdata_valid;
                wrdataReady = i_bp_ready;
            end
            RSP: begin
                rspData  = i_bp_data;
                rspValid = i_bp_valid;
                bpReady  = i_rsp_ready;
                // Writes reach RSP with beatCnt already 0, so one byte is last.
                rspLast  = (beatCnt == 8'd0);
            end
            default: ;
        endcase
        if (!i_cg) begin
            bpValid     = 1'b0;
            bpReady     = 1'b0;
            rspValid    = 1'b0;
            rspLast     = 1'b0;
            wrdataReady = 1'b0;
        end
    end

    assign rspState = (state == SETUP_RSP) || (state == RSP);
    assign bpFire   = bpValid && i_bp_ready;
    assign rspFire  = bpReady && i_bp_valid;
    // Only a silent link counts; a byte held by i_rsp_ready=0 is not idle.
    assign toExpire = rspState && !i_bp_valid && (toCnt == TO_FIRE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            reqWr      <= 1'b0;
            reqAddr    <= 7'd0;
            reqLen     <= 8'd0;
            beatCnt    <= 8'd0;
            toCnt      <= '0;
            timeoutReg <= 1'b0;
        end else if (i_cg) begin
            if (rspState) begin
                if (rspFire) begin
                    toCnt <= '0;
                end else if (!i_bp_valid) begin
                    toCnt <= toExpire ? '0 : toCnt + 1'b1;
                end
            end
            if (toExpire) begin
                timeoutReg <= 1'b1;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_req_valid) begin
                            reqWr      <= i_req_wr;
                            reqAddr    <= i_req_addr;
                            reqLen     <= i_req_len;
                            beatCnt    <= 8'd0;
                            toCnt      <= '0;
                            timeoutReg <= 1'b0;
                            state      <= (i_req_len != 8'd0) ? SETUP_CMD : CMD;
                        end
                    end
                    SETUP_CMD: if (i_bp_ready) state <= SETUP_DAT;
                    SETUP_DAT: if (i_bp_ready) state <= SETUP_RSP;
                    SETUP_RSP: if (rspFire) state <= CMD;
                    CMD: begin
                        if (i_bp_ready) begin
                            beatCnt <= reqLen;
                            state   <= reqWr ? WDATA : RSP;
                        end
                    end
                    WDATA: begin
                        // Decide on the pre-decrement value so len=255 gives 256 beats.
                        if (bpFire) begin
                            if (beatCnt == 8'd0) state <= RSP;
                            else beatCnt <= beatCnt - 8'd1;
                        end
                    end
                    RSP: begin
                        if (rspFire) begin
                            if (beatCnt == 8'd0) state <= IDLE;
                            else beatCnt <= beatCnt - 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_req_ready    = (state == IDLE) && i_cg;
    assign o_wrdata_ready = wrdataReady;
    assign o_rsp_data     = rspData;
    assign o_rsp_valid    = rspValid;
    assign o_rsp_last     = rspLast;
    assign o_bp_data      = bpData;
    assign o_bp_valid     = bpValid;
    assign o_bp_ready     = bpReady;
    assign o_busy         = (state != IDLE);
    assign o_timeout      = timeoutReg;

endmodule

// File: tb/tb_bp_initiator.sv
// tb/tb_bp_initiator.sv - directed self-checking bench for bp_initiator
module tb_bp_initiator;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cg;
    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_req_wr;
    logic [6:0] i_req_addr;
    logic [7:0] i_req_len;
    logic [7:0] i_wrdata;
    logic       i_wrdata_valid;
    logic       o_wrdata_ready;
    logic [7:0] o_rsp_data;
    logic       o_rsp_valid;
    logic       o_rsp_last;
    logic       i_rsp_ready;
    logic [7:0] o_bp_data;
    logic       o_bp_valid;
    logic       i_bp_ready;
    logic [7:0] i_bp_data;
    logic       i_bp_valid;
    logic       o_bp_ready;
    logic       o_busy;
    logic       o_timeout;

    int checkCount = 0;
    int errorCount = 0;

    bp_initiator #(.TIMEOUT_W(4), .DISCARD_SETUP_RSP(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len),
        .i_wrdata(i_wrdata), .i_wrdata_valid(i_wrdata_valid), .o_wrdata_ready(o_wrdata_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .o_rsp_last(o_rsp_last),
        .i_rsp_ready(i_rsp_ready),
        .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready),
        .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sendReq(input logic wr, input logic [6:0] addr, input logic [7:0] len);
        int n = 0;
        i_req_valid = 1'b1;
        i_req_wr    = wr;
        i_req_addr  = addr;
        i_req_len   = len;
        #1;
        while (!o_req_ready && n < 20) begin tick(); n++; end
        checkVal("req_ready", o_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic expectBp(input string tag, input logic [7:0] exp);
        int n = 0;
        i_bp_ready = 1'b1;
        #1;
        while (!o_bp_valid && n < 20) begin tick(); n++; end
        checkVal({tag, "_valid"}, o_bp_valid, 1);
        checkVal(tag, o_bp_data, exp);
        tick();
        i_bp_ready = 1'b0;
    endtask

    task automatic giveRsp(input string tag, input logic [7:0] data, input logic expLast, input logic expFwd);
        int n = 0;
        i_bp_valid  = 1'b1;
        i_bp_data   = data;
        i_rsp_ready = 1'b1;
        #1;
        while (!o_bp_ready && n < 20) begin tick(); n++; end
        checkVal({tag, "_bpready"}, o_bp_ready, 1);
        checkVal({tag, "_valid"}, o_rsp_valid, expFwd);
        if (expFwd) checkVal(tag, o_rsp_data, data);
        checkVal({tag, "_last"}, o_rsp_last, expLast);
        tick();
        i_bp_valid  = 1'b0;
        i_rsp_ready = 1'b0;
    endtask

    logic [7:0] wrB[3] = '{8'h31, 8'h32, 8'h33};

    initial begin
        i_rst = 1'b1; i_cg = 1'b1;
        i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = 7'd0; i_req_len = 8'd0;
        i_wrdata = 8'h00; i_wrdata_valid = 1'b0; i_rsp_ready = 1'b0;
        i_bp_ready = 1'b0; i_bp_data = 8'h00; i_bp_valid = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        #1;
        checkVal("rst_busy", o_busy, 0);
        checkVal("rst_timeout", o_timeout, 0);
        checkVal("rst_bp_valid", o_bp_valid, 0);
        checkVal("rst_rsp_valid", o_rsp_valid, 0);
        checkVal("rst_wrdata_ready", o_wrdata_ready, 0);

        // single read
        sendReq(1'b0, 7'h15, 8'd0);
        checkVal("rd_busy", o_busy, 1);
        expectBp("rd_cmd", 8'h15);
        giveRsp("rd_rsp", 8'h20, 1'b1, 1'b1);
        checkVal("rd_idle", o_busy, 0);

        // single write
        sendReq(1'b1, 7'h19, 8'd0);
        expectBp("wr_cmd", 8'h99);
        i_wrdata = 8'h05; i_wrdata_valid = 1'b1; i_bp_ready = 1'b1;
        #1;
        checkVal("wr_dat_valid", o_bp_valid, 1);
        checkVal("wr_dat", o_bp_data, 8'h05);
        checkVal("wr_dat_ready", o_wrdata_ready, 1);
        tick();
        i_wrdata_valid = 1'b0; i_bp_ready = 1'b0;
        giveRsp("wr_rb", 8'h05, 1'b1, 1'b1);
        checkVal("wr_idle", o_busy, 0);

        // burst read len=3
        sendReq(1'b0, 7'h11, 8'd3);
        expectBp("br_setup_cmd", 8'h80);
        expectBp("br_setup_len", 8'h03);
        giveRsp("br_setup_rb", 8'h5A, 1'b0, 1'b0);
        expectBp("br_cmd", 8'h11);
        // clock gate off blocks the response handshake and holds state
        i_cg = 1'b0; i_bp_valid = 1'b1; i_bp_data = 8'hA0; i_rsp_ready = 1'b1;
        #1;
        checkVal("cg_rsp_valid", o_rsp_valid, 0);
        checkVal("cg_bp_ready", o_bp_ready, 0);
        tick();
        i_cg = 1'b1;
        giveRsp("br_rsp0", 8'hA0, 1'b0, 1'b1);
        giveRsp("br_rsp1", 8'hA1, 1'b0, 1'b1);
        giveRsp("br_rsp2", 8'hA2, 1'b0, 1'b1);
        giveRsp("br_rsp3", 8'hA3, 1'b1, 1'b1);
        checkVal("br_idle", o_busy, 0);

        // burst write len=2 with random stalls
        sendReq(1'b1, 7'h19, 8'd2);
        expectBp("bw_setup_cmd", 8'h80);
        expectBp("bw_setup_len", 8'h02);
        giveRsp("bw_setup_rb", 8'h02, 1'b0, 1'b0);
        expectBp("bw_cmd", 8'h99);
        begin
            int idx = 0;
            int n = 0;
            while (idx < 3 && n < 200) begin
                i_bp_ready     = 1'($urandom_range(0, 1));
                i_wrdata_valid = 1'($urandom_range(0, 1));
                i_wrdata       = wrB[idx];
                #1;
                checkVal("bw_valid", o_bp_valid, i_wrdata_valid);
                checkVal("bw_ready", o_wrdata_ready, i_bp_ready);
                if (i_wrdata_valid && o_wrdata_ready) begin
                    checkVal("bw_data", o_bp_data, wrB[idx]);
                    idx++;
                end
                tick();
                n++;
            end
            checkVal("bw_count", idx, 3);
        end
        i_wrdata_valid = 1'b1; i_bp_ready = 1'b1;
        #1;
        checkVal("bw_no_dup", o_bp_valid, 0);
        i_wrdata_valid = 1'b0; i_bp_ready = 1'b0;
        giveRsp("bw_rb", 8'h33, 1'b1, 1'b1);
        checkVal("bw_idle", o_busy, 0);

        // timeout after 15 silent cycles
        sendReq(1'b0, 7'h22, 8'd0);
        expectBp("to_cmd", 8'h22);
        repeat (14) tick();
        checkVal("to_busy14", o_busy, 1);
        checkVal("to_flag14", o_timeout, 0);
        tick();
        checkVal("to_busy15", o_busy, 0);
        checkVal("to_flag15", o_timeout, 1);
        sendReq(1'b0, 7'h22, 8'd0);
        checkVal("to_cleared", o_timeout, 0);
        expectBp("to_cmd2", 8'h22);
        giveRsp("to_rsp2", 8'h44, 1'b1, 1'b1);

        // reset mid write burst
        sendReq(1'b1, 7'h19, 8'd2);
        expectBp("rw_setup_cmd", 8'h80);
        expectBp("rw_setup_len", 8'h02);
        giveRsp("rw_setup_rb", 8'h02, 1'b0, 1'b0);
        expectBp("rw_cmd", 8'h99);
        i_wrdata = 8'h61; i_wrdata_valid = 1'b1; i_bp_ready = 1'b1;
        tick();
        i_rst = 1'b1;
        tick();
        checkVal("rw_busy", o_busy, 0);
        checkVal("rw_bp_valid", o_bp_valid, 0);
        checkVal("rw_wrdata_ready", o_wrdata_ready, 0);
        i_rst = 1'b0; i_wrdata_valid = 1'b0; i_bp_ready = 1'b0;
        sendReq(1'b0, 7'h15, 8'd0);
        expectBp("rw_rd_cmd", 8'h15);
        giveRsp("rw_rd_rsp", 8'h33, 1'b1, 1'b1);
        checkVal("rw_rd_idle", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/bp_initiator.md
Name: bp_initiator

Overview:
- BytePipe initiator: the host/requester end of the BytePipe register protocol served by the correlator register block.
- Converts one transaction request (read/write, 7b address, burst length) into a command byte stream and returns response bytes to a local consumer.
- Sits between a local controller (test sequencer, soft CPU bridge or loopback harness) and a BytePipe link to a register responder.
- Handles burst setup, write readback and response timeout.

Parameters:
- TIMEOUT_W, 16, width of the response-timeout counter. Timeout fires after 2^TIMEOUT_W-1 idle cycles waiting for a response byte.
- DISCARD_SETUP_RSP, 1, when 1 the readback byte of the burst-setup write is consumed internally and not forwarded.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_cg  in  1  clock-gate enable; when 0 all state holds
- i_req_valid  in  1  transaction request valid
- o_req_ready  out  1  request accepted (high only in IDLE)
- i_req_wr  in  1  1=write, 0=read
- i_req_addr  in  7  register address (1..127; 0 reserved for burst setup)
- i_req_len  in  8  extra beats: total beats = len+1
- i_wrdata  in  8  write data byte stream
- i_wrdata_valid  in  1  write data valid
- o_wrdata_ready  out  1  write data accepted
- o_rsp_data  out  8  response byte
- o_rsp_valid  out  1  response valid
- o_rsp_last  out  1  final response byte of transaction
- i_rsp_ready  in  1  consumer ready
- o_bp_data  out  8  BytePipe to responder
- o_bp_valid  out  1
- i_bp_ready  in  1
- i_bp_data  in  8  BytePipe from responder
- i_bp_valid  in  1
- o_bp_ready  out  1
- o_busy  out  1  not IDLE
- o_timeout  out  1  sticky; set on timeout, cleared by reset or next accepted request

Behaviour:
- Command byte format: {wr, addr[6:0]}.
- Burst-setup write: command 0x80 followed by one data byte equal to len. The responder returns one readback byte for it.
- Reset: FSM=IDLE. o_bp_valid, o_rsp_valid, o_rsp_last, o_wrdata_ready, o_busy, o_timeout all 0. Beat and timeout counters 0.
- Request capture:
  - Request accepted when i_req_valid && o_req_ready. Captures wr, addr, len.
  - Clears o_timeout.
  - Next state is SETUP_CMD if len!=0, else CMD.
- FSM states:
  - IDLE.
  - SETUP_CMD: drive 0x80 with o_bp_valid=1. Go to SETUP_DAT on i_bp_ready.
  - SETUP_DAT: drive len. Go to SETUP_RSP on i_bp_ready.
  - SETUP_RSP: o_bp_ready=1. Accept one byte and discard it (forward it, with o_rsp_last=0, if DISCARD_SETUP_RSP=0). Go to CMD.
  - CMD: drive {wr, addr}. On i_bp_ready go to WDATA if wr, else RSP. Beat counter loads len.
  - WDATA:
    - o_bp_data=i_wrdata, o_bp_valid=i_wrdata_valid, o_wrdata_ready=i_bp_ready. Combinational pass-through, zero latency.
    - Each transfer decrements the beat counter.
    - The transfer made with counter==0 goes to RSP, expecting exactly 1 readback byte.
  - RSP:
    - o_rsp_data=i_bp_data, o_rsp_valid=i_bp_valid, o_bp_ready=i_rsp_ready. Pass-through, zero latency.
    - Read: len+1 bytes expected, counter decrements per byte.
    - Write: 1 byte expected.
    - o_rsp_last=1 on the final expected byte. Its acceptance returns to IDLE.
- Counter underflow: the beat counter never wraps. len=255 gives 256 beats. The state decision uses counter==0 before decrement.
- Timeout:
  - Counter runs in SETUP_RSP and RSP while i_bp_valid=0. It clears on any accepted response byte.
  - At all-ones: set o_timeout, return to IDLE, and drop remaining beats.
  - Stalls caused by i_rsp_ready=0 do not count.
- No o_bp_valid in IDLE or in any response state. No more than one outstanding transaction.
- Ignored inputs:
  - i_wrdata_valid is ignored outside WDATA.
  - Bytes arriving on i_bp_data in non-response states are not accepted (o_bp_ready=0).
- Reset mid-transaction: return to IDLE immediately. All outputs take their reset values the next cycle, and partial bursts are abandoned.
- i_cg=0: state and counters hold. The combinational pass-through handshakes are also gated off (ready/valid outputs forced 0).

Test Plan:
- Single read: req rd addr=0x15 len=0 → o_bp_data 0x15. Responder returns 0x20 → o_rsp_data=0x20 with o_rsp_last=1, then IDLE.
- Single write: req wr addr=0x19 len=0, wrdata 0x05 → bytes 0x99, 0x05. Readback 0x05 forwarded with last=1.
- Burst read: req rd addr=0x11 len=3, FIFO holds 0xA0..0xA3 → bytes 0x80, 0x03, setup readback discarded, then 0x11. Four responses 0xA0..0xA3, last only on 0xA3.
- Burst write len=2 with random i_bp_ready/i_wrdata_valid stalls → exactly 3 data bytes sent in order, 1 readback, no duplication.
- Timeout: TIMEOUT_W=4, responder silent after read cmd → o_timeout=1 after 15 cycles, FSM in IDLE, next request clears o_timeout.
- Reset asserted in WDATA mid-burst → next cycle o_busy=0, o_bp_valid=0. Subsequent single read completes normally.
